// File: rtl/ahbl_sram64_ctrl.sv
// ahbl_sram64_ctrl: AHB-Lite slave in front of a single-port synchronous
// 64-bit SRAM macro. All legal transfers complete with zero wait states.
// A one-entry write buffer absorbs the collision between a write data phase
// and a read address phase. Illegal size or alignment gets a two-cycle ERROR.
//
// Ports:
//   HCLK, HRESETn           clock, asynchronous active-low reset
//   HSEL..HREADY            AHB-Lite slave inputs (address/control, write data)
//   HREADYOUT, HRESP        slave ready / ERROR response
//   HRDATA                  read data (data phase)
//   SRAMRDATA               macro read data, valid the cycle after a read strobe
//   SRAMCS0, SRAMWEN        macro enable and per-byte write enable
//   SRAMADDR, SRAMWDATA     macro word address and write data
module ahbl_sram64_ctrl #(
  parameter int AW     = 32,
  parameter int ADDR_W = 10
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [AW-1:0]     HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [63:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [63:0]       HRDATA,
  input  logic [63:0]       SRAMRDATA,
  output logic [7:0]        SRAMWEN,
  output logic [63:0]       SRAMWDATA,
  output logic              SRAMCS0,
  output logic [ADDR_W-1:0] SRAMADDR
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_WR   = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  // 2**size consecutive byte lanes starting at the addressed lane.
  function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [2:0] lane);
    logic [7:0] base;
    case (size)
      3'd0:    base = 8'h01;
      3'd1:    base = 8'h03;
      3'd2:    base = 8'h0F;
      3'd3:    base = 8'hFF;
      default: base = 8'h00;
    endcase
    return base << lane;
  endfunction

  // Size must fit the 64-bit bus and the address must be naturally aligned.
  function automatic logic is_legal(input logic [2:0] size, input logic [2:0] lane);
    logic ok;
    case (size)
      3'd0:    ok = 1'b1;
      3'd1:    ok = (lane[0] == 1'b0);
      3'd2:    ok = (lane[1:0] == 2'b00);
      3'd3:    ok = (lane == 3'b000);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_mask_q, wr_mask_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [7:0]        buf_mask_q, buf_mask_d;
  logic [63:0]       buf_data_q, buf_data_d;

  logic              accept_s, legal_s, rd_accept_s, wr_accept_s, err_accept_s;
  logic              wr_due_s, buf_hit_s;
  logic [ADDR_W-1:0] word_addr_s;
  logic [63:0]       rd_merged_s;
  logic              unused_s;

  assign accept_s     = HSEL & HREADY & HTRANS[1];
  assign legal_s      = is_legal(HSIZE, HADDR[2:0]);
  assign rd_accept_s  = accept_s & legal_s & ~HWRITE;
  assign wr_accept_s  = accept_s & legal_s & HWRITE;
  assign err_accept_s = accept_s & ~legal_s;
  // Upper address bits are dropped, so the SRAM aliases across the slot.
  assign word_addr_s  = HADDR[ADDR_W+2:3];
  assign wr_due_s     = (state_q == ST_WR);
  assign buf_hit_s    = buf_valid_q & (buf_addr_q == rd_addr_q);
  assign unused_s     = ^{HADDR[AW-1:ADDR_W+3], HTRANS[0]};

  assign HREADYOUT = (state_q != ST_ERR1);
  assign HRESP     = (state_q == ST_ERR1) | (state_q == ST_ERR2);

  // Next state and address-phase capture of the transfer attributes.
  always_comb begin
    state_d   = ST_IDLE;
    wr_addr_d = wr_addr_q;
    wr_mask_d = wr_mask_q;
    rd_addr_d = rd_addr_q;
    if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
    end else if (rd_accept_s) begin
      state_d   = ST_RD;
      rd_addr_d = word_addr_s;
    end else if (wr_accept_s) begin
      state_d   = ST_WR;
      wr_addr_d = word_addr_s;
      wr_mask_d = lane_mask(HSIZE, HADDR[2:0]);
    end else if (err_accept_s) begin
      state_d = ST_ERR1;
    end else begin
      state_d = ST_IDLE;
    end
  end

  // Write buffer: fill when a read steals the port from a write data phase,
  // empty on the first cycle the port is otherwise free.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_mask_d  = buf_mask_q;
    buf_data_d  = buf_data_q;
    if (wr_due_s && rd_accept_s) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = wr_addr_q;
      buf_mask_d  = wr_mask_q;
      buf_data_d  = HWDATA;
    end else if (buf_valid_q && !rd_accept_s && !wr_due_s) begin
      buf_valid_d = 1'b0;
    end else begin
      buf_valid_d = buf_valid_q;
    end
  end

  // SRAM port arbitration: read accept, then direct write, then drain.
  always_comb begin
    SRAMCS0   = 1'b0;
    SRAMWEN   = 8'h00;
    SRAMADDR  = {ADDR_W{1'b0}};
    SRAMWDATA = 64'd0;
    if (rd_accept_s) begin
      SRAMCS0  = 1'b1;
      SRAMADDR = word_addr_s;
    end else if (wr_due_s) begin
      SRAMCS0   = 1'b1;
      SRAMWEN   = wr_mask_q;
      SRAMADDR  = wr_addr_q;
      SRAMWDATA = HWDATA;
    end else if (buf_valid_q) begin
      SRAMCS0   = 1'b1;
      SRAMWEN   = buf_mask_q;
      SRAMADDR  = buf_addr_q;
      SRAMWDATA = buf_data_q;
    end else begin
      SRAMCS0 = 1'b0;
    end
  end

  // Read data: SRAM word with any newer buffered bytes for the same word.
  always_comb begin
    rd_merged_s = SRAMRDATA;
    for (int i = 0; i < 8; i++) begin
      if (buf_hit_s && buf_mask_q[i]) begin
        rd_merged_s[i*8 +: 8] = buf_data_q[i*8 +: 8];
      end else begin
        rd_merged_s[i*8 +: 8] = SRAMRDATA[i*8 +: 8];
      end
    end
    if (state_q == ST_RD) begin
      HRDATA = rd_merged_s;
    end else begin
      HRDATA = 64'd0;
    end
  end

  // State registers; reset discards any buffered write.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      wr_addr_q   <= {ADDR_W{1'b0}};
      wr_mask_q   <= 8'h00;
      rd_addr_q   <= {ADDR_W{1'b0}};
      buf_valid_q <= 1'b0;
      buf_addr_q  <= {ADDR_W{1'b0}};
      buf_mask_q  <= 8'h00;
      buf_data_q  <= 64'd0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      wr_mask_q   <= wr_mask_d;
      rd_addr_q   <= rd_addr_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_mask_q  <= buf_mask_d;
      buf_data_q  <= buf_data_d;
    end
  end

endmodule
